gray_count_monitor: RTL and testbench



---
 rtl/gray_count_monitor.sv | 145 ++++++++++++++
 tb/tb_gray_count_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_count_monitor.sv
// Registers an upstream Gray-code counter and converts it to binary.
// Also checks Gray step legality, counts overflow wraps and offers a valid/ready snapshot port.
module gray_count_monitor #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WRAP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  gray_in,
    input  logic              ovf_in,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  bin_out,
    output logic              bin_valid,
    output logic              step_err,
    output logic [WRAP_W-1:0] wrap_count,
    input  logic              snap_req,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic [WIDTH-1:0]  snap_bin,
    output logic [WRAP_W-1:0] snap_wraps
);

    typedef enum logic {
        SNAP_IDLE,
        SNAP_HOLD
    } snap_state_e;

    logic [WIDTH-1:0]  g_q, g_d;
    logic [WIDTH-1:0]  g_prev_q, g_prev_d;
    logic              ovf_q, ovf_d;
    logic              ovf_prev_q, ovf_prev_d;
    logic              s1_vld_q, s1_vld_d;
    logic              prev_vld_q, prev_vld_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic              bin_valid_q, bin_valid_d;
    logic              step_err_q, step_err_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;

    logic [WIDTH-1:0]  bin_conv;
    logic [WIDTH-1:0]  step_diff;
    logic              multi_bit;
    logic              ovf_rise;

    snap_state_e       state_q;
    logic              snap_valid_q;
    logic [WIDTH-1:0]  snap_bin_q;
    logic [WRAP_W-1:0] snap_wraps_q;

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        bin_conv = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_conv[i] = ^(g_q >> i);
        end
    end

    always_comb begin
        step_diff = g_q ^ g_prev_q;
        multi_bit = |(step_diff & (step_diff - WIDTH'(1)));
        ovf_rise  = ovf_q & ~ovf_prev_q;
    end

    always_comb begin
        g_d         = gray_in;
        ovf_d       = ovf_in;
        s1_vld_d    = 1'b1;
        g_prev_d    = g_q;
        ovf_prev_d  = ovf_q;
        prev_vld_d  = s1_vld_q;
        bin_d       = s1_vld_q ? bin_conv : bin_q;
        bin_valid_d = s1_vld_q;
        // A fresh error outranks a simultaneous clear.
        step_err_d  = (prev_vld_q & multi_bit) | (step_err_q & ~err_clr);
        wrap_d      = wrap_q;
        if (ovf_rise && (wrap_q != '1)) begin
            wrap_d = wrap_q + WRAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q         <= '0;
            ovf_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            g_prev_q    <= '0;
            ovf_prev_q  <= 1'b0;
            prev_vld_q  <= 1'b0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= '0;
        end else begin
            g_q         <= g_d;
            ovf_q       <= ovf_d;
            s1_vld_q    <= s1_vld_d;
            g_prev_q    <= g_prev_d;
            ovf_prev_q  <= ovf_prev_d;
            prev_vld_q  <= prev_vld_d;
            bin_q       <= bin_d;
            bin_valid_q <= bin_valid_d;
            step_err_q  <= step_err_d;
            wrap_q      <= wrap_d;
        end
    end

    // Requests arriving while HOLD (including on the handshake edge) are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SNAP_IDLE;
            snap_valid_q <= 1'b0;
            snap_bin_q   <= '0;
            snap_wraps_q <= '0;
        end else begin
            case (state_q)
                SNAP_IDLE: begin
                    if (snap_req && bin_valid_q) begin
                        snap_bin_q   <= bin_q;
                        snap_wraps_q <= wrap_q;
                        snap_valid_q <= 1'b1;
                        state_q      <= SNAP_HOLD;
                    end
                end
                SNAP_HOLD: begin
                    if (snap_ready) begin
                        snap_valid_q <= 1'b0;
                        state_q      <= SNAP_IDLE;
                    end
                end
                default: begin
                    snap_valid_q <= 1'b0;
                    state_q      <= SNAP_IDLE;
                end
            endcase
        end
    end

    assign bin_out    = bin_q;
    assign bin_valid  = bin_valid_q;
    assign step_err   = step_err_q;
    assign wrap_count = wrap_q;
    assign snap_valid = snap_valid_q;
    assign snap_bin   = snap_bin_q;
    assign snap_wraps = snap_wraps_q;

endmodule

// File: tb/tb_gray_count_monitor.sv
// Self-checking bench for gray_count_monitor: directed sequences, a snapshot vector table
// and a queue scoreboard for the Gray-to-binary data path.
module tb_gray_count_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  gray_in;
    logic        ovf_in;
    logic        err_clr;
    logic        snap_req;
    logic        snap_ready;

    logic [7:0]  bin_out;
    logic        bin_valid;
    logic        step_err;
    logic [15:0] wrap_count;
    logic        snap_valid;
    logic [7:0]  snap_bin;
    logic [15:0] snap_wraps;

    logic [7:0]  s_bin_out;
    logic        s_bin_valid;
    logic        s_step_err;
    logic [1:0]  s_wrap_count;
    logic        s_snap_valid;
    logic [7:0]  s_snap_bin;
    logic [1:0]  s_snap_wraps;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    gray_count_monitor #(.WIDTH(8), .WRAP_W(16)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .ovf_in(ovf_in), .err_clr(err_clr),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err),
        .wrap_count(wrap_count), .snap_req(snap_req), .snap_valid(snap_valid),
        .snap_ready(snap_ready), .snap_bin(snap_bin), .snap_wraps(snap_wraps)
    );

    gray_count_monitor #(.WIDTH(8), .WRAP_W(2)) dut_sat (
        .clk(clk), .rst(rst), .gray_in(gray_in), .ovf_in(ovf_in), .err_clr(err_clr),
        .bin_out(s_bin_out), .bin_valid(s_bin_valid), .step_err(s_step_err),
        .wrap_count(s_wrap_count), .snap_req(snap_req), .snap_valid(s_snap_valid),
        .snap_ready(snap_ready), .snap_bin(s_snap_bin), .snap_wraps(s_snap_wraps)
    );

    typedef struct {
        int         due;
        logic [7:0] val;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [7:0]  gray;
        logic        req;
        logic        ready;
        logic        exp_valid;
        logic        chk_data;
        logic [7:0]  exp_bin;
        logic [15:0] exp_wraps;
    } snap_vec_t;
    snap_vec_t vecs[10];

    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bin_out"},    32'(bin_out),    32'd0);
        chk({tag, "_bin_valid"},  32'(bin_valid),  32'd0);
        chk({tag, "_step_err"},   32'(step_err),   32'd0);
        chk({tag, "_wrap_count"}, 32'(wrap_count), 32'd0);
        chk({tag, "_snap_valid"}, 32'(snap_valid), 32'd0);
        chk({tag, "_snap_bin"},   32'(snap_bin),   32'd0);
        chk({tag, "_snap_wraps"}, 32'(snap_wraps), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; gray_in = 8'h00; ovf_in = 1'b0; err_clr = 1'b0;
        snap_req = 1'b0; snap_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic sb_service();
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            sb_t e;
            e = sbq.pop_front();
            chk("sb_bin_out", 32'(bin_out), 32'(e.val));
            chk("sb_bin_valid", 32'(bin_valid), 32'd1);
        end
    endtask

    task automatic ovf_pulse();
        ovf_in = 1'b1; tick();
        ovf_in = 1'b0; tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h18, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 16'd2};
        vecs[1] = '{8'h19, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 16'd2};
        vecs[2] = '{8'h1B, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 16'd2};
        vecs[3] = '{8'h1A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 16'd2};
        vecs[4] = '{8'h1E, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 16'd2};
        vecs[5] = '{8'h1E, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
        vecs[6] = '{8'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
        vecs[7] = '{8'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
        vecs[8] = '{8'h1E, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 16'd2};
        vecs[9] = '{8'h1E, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};

        // Reset held for two edges with activity on the inputs
        rst = 1'b1; gray_in = 8'h5A; ovf_in = 1'b0; err_clr = 1'b0;
        snap_req = 1'b1; snap_ready = 1'b0;
        tick(); chk_all_zero("rst_e1");
        tick(); chk_all_zero("rst_e2");
        rst = 1'b0; snap_req = 1'b0;
        tick(); chk("rel_e1_bin_valid", 32'(bin_valid), 32'd0);
        tick(); chk("rel_e2_bin_valid", 32'(bin_valid), 32'd1);
        chk("rel_e2_bin_out", 32'(bin_out), 32'h6C);
        chk("rel_e2_step_err", 32'(step_err), 32'd0);

        // Full Gray sequence 0..255 then 0, scoreboarded with 2-edge latency
        do_reset();
        for (int n = 0; n <= 256; n++) begin
            logic [7:0] nb;
            nb = 8'(n);
            gray_in = bin2gray(nb);
            sbq.push_back('{cyc + 2, nb});
            tick();
            sb_service();
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            sb_service();
        end
        chk("seq_sb_drained", 32'(sbq.size()), 32'd0);
        chk("seq_step_err", 32'(step_err), 32'd0);

        // Illegal step 0x00 -> 0x03, sticky, clear, and set-wins-over-clear
        gray_in = 8'h03; tick();
        chk("ill_before", 32'(step_err), 32'd0);
        tick(); chk("ill_set", 32'(step_err), 32'd1);
        tick(); chk("ill_sticky", 32'(step_err), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ill_clr", 32'(step_err), 32'd0);
        gray_in = 8'h01; tick();
        gray_in = 8'h00; tick();
        tick(); tick();
        chk("ill_legal_walk", 32'(step_err), 32'd0);
        gray_in = 8'h0F; tick();
        chk("ill2_before", 32'(step_err), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ill2_set_wins", 32'(step_err), 32'd1);
        tick(); chk("ill2_sticky", 32'(step_err), 32'd1);

        // Wrap counting, held-high overflow, and 2-bit saturation
        do_reset();
        ovf_in = 1'b1; tick();
        chk("wrap_lat_before", 32'(wrap_count), 32'd0);
        ovf_in = 1'b0; tick();
        chk("wrap_lat_after", 32'(wrap_count), 32'd1);
        ovf_pulse();
        ovf_pulse();
        chk("wrap_three", 32'(wrap_count), 32'd3);
        chk("wrap_sat_three", 32'(s_wrap_count), 32'd3);
        ovf_in = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        ovf_in = 1'b0; tick(); tick();
        chk("wrap_held_once", 32'(wrap_count), 32'd4);
        ovf_pulse(); tick();
        chk("wrap_five", 32'(wrap_count), 32'd5);
        chk("wrap_sat_hold", 32'(s_wrap_count), 32'd3);

        // Snapshot backpressure from the vector table
        do_reset();
        ovf_pulse();
        ovf_pulse();
        gray_in = 8'h08; tick();
        gray_in = 8'h18; tick(); tick(); tick();
        chk("snap_pre_bin", 32'(bin_out), 32'h10);
        chk("snap_pre_wraps", 32'(wrap_count), 32'd2);
        chk("snap_pre_valid", 32'(snap_valid), 32'd0);
        for (int v = 0; v < 10; v++) begin
            gray_in    = vecs[v].gray;
            snap_req   = vecs[v].req;
            snap_ready = vecs[v].ready;
            tick();
            chk($sformatf("snap_v%0d_valid", v), 32'(snap_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].chk_data) begin
                chk($sformatf("snap_v%0d_bin", v), 32'(snap_bin), 32'(vecs[v].exp_bin));
                chk($sformatf("snap_v%0d_wraps", v), 32'(snap_wraps), 32'(vecs[v].exp_wraps));
            end
        end
        snap_req = 1'b0; snap_ready = 1'b0;

        // Reset while in HOLD with wrap_count = 3 and step_err = 1
        ovf_pulse();
        gray_in = 8'h01; tick(); tick();
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        chk("mid_hold_valid", 32'(snap_valid), 32'd1);
        chk("mid_wraps", 32'(wrap_count), 32'd3);
        chk("mid_step_err", 32'(step_err), 32'd1);
        chk("mid_snap_wraps", 32'(snap_wraps), 32'd3);
        rst = 1'b1; gray_in = 8'h5A; snap_req = 1'b1;
        tick(); chk_all_zero("mid_rst");
        rst = 1'b0;
        tick(); chk("post_e1_snap_valid", 32'(snap_valid), 32'd0);
        tick(); chk("post_e2_snap_valid", 32'(snap_valid), 32'd0);
        chk("post_e2_bin_valid", 32'(bin_valid), 32'd1);
        tick(); chk("post_e3_snap_valid", 32'(snap_valid), 32'd1);
        chk("post_e3_snap_bin", 32'(snap_bin), 32'(gray2bin(8'h5A)));
        chk("post_e3_snap_wraps", 32'(snap_wraps), 32'd0);
        chk("post_e3_step_err", 32'(step_err), 32'd0);
        snap_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
